// File: rtl/bus_sram_slave_pkg.sv
// Shared definitions for the SRAM bus slave: FSM state encoding, bus response codes
// and the address decode helper.
package bus_sram_slave_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StAck   = 2'd2,
    StDrain = 2'd3
  } bus_state_e;

  // Response codes, packed as {err, ack}.
  localparam logic [1:0] BusRespOk  = 2'b01;
  localparam logic [1:0] BusRespErr = 2'b11;

  // True when a word address falls inside the window of 2^depth_log2 words at base.
  function automatic logic addr_in_range(input logic [29:0] word_addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_log2);
    return (word_addr >> depth_log2) == (base[31:2] >> depth_log2);
  endfunction

endpackage

// File: rtl/bus_sram_array.sv
// Word-wide RAM with a synchronous byte-lane write port and an asynchronous read port.
module bus_sram_array #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_byte_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_idx,
  output logic [31:0]           o_rd_data
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0] mem [Words];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_en[b]) begin
          mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign o_rd_data = mem[i_rd_idx];

endmodule

// File: rtl/bus_sram_slave.sv
// Simple request/ack bus slave in front of a byte-enable SRAM, with configurable wait
// states and an error response for addresses outside the mapped window.
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_err
);

  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_e state;
  logic [3:0] cnt;

  logic        wr_q;
  logic [29:0] word_q;
  logic [31:0] wr_data_q;
  logic [3:0]  byte_en_q;

  logic                  cur_wr;
  logic [29:0]           cur_word;
  logic [31:0]           cur_data;
  logic [3:0]            cur_be;
  logic                  cur_in_range;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  enter_ack;
  logic                  mem_we;
  logic [31:0]           mem_rd_data;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  // With zero wait states the access completes straight off the bus inputs.
  always_comb begin
    cur_wr   = wr_q;
    cur_word = word_q;
    cur_data = wr_data_q;
    cur_be   = byte_en_q;
    if (state == StIdle) begin
      cur_wr   = i_wr_en;
      cur_word = i_addr[31:2];
      cur_data = i_wr_data;
      cur_be   = i_byte_en;
    end
  end

  assign cur_in_range = addr_in_range(cur_word, BASE_ADDR, DEPTH_LOG2);
  assign cur_idx      = cur_word[DEPTH_LOG2-1:0];

  always_comb begin
    enter_ack = 1'b0;
    unique case (state)
      StIdle:  enter_ack = i_bus_en && (WAIT_STATES == 0);
      StWait:  enter_ack = i_bus_en && (cnt == 4'd0);
      default: enter_ack = 1'b0;
    endcase
  end

  // Gated by reset so a write cut short by reset never commits.
  assign mem_we = i_rst && enter_ack && cur_wr && cur_in_range;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= StIdle;
      cnt       <= 4'd0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rd_data <= 32'd0;
    end else begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rd_data <= 32'd0;
      if (enter_ack) begin
        {o_err, o_ack} <= cur_in_range ? BusRespOk : BusRespErr;
        o_rd_data      <= (cur_in_range && !cur_wr) ? mem_rd_data : 32'd0;
      end
      unique case (state)
        StIdle: begin
          if (i_bus_en) begin
            if (WAIT_STATES == 0) begin
              state <= StAck;
            end else begin
              state <= StWait;
              cnt   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (!i_bus_en) begin
            state <= StIdle;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= StAck;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StAck:   state <= StDrain;
        StDrain: if (!i_bus_en) state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == StIdle && i_bus_en) begin
      wr_q      <= i_wr_en;
      word_q    <= i_addr[31:2];
      wr_data_q <= i_wr_data;
      byte_en_q <= i_byte_en;
    end
  end

  bus_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk    (i_clk),
    .i_wr_en  (mem_we),
    .i_wr_idx (cur_idx),
    .i_wr_data(cur_data),
    .i_byte_en(cur_be),
    .i_rd_idx (cur_idx),
    .o_rd_data(mem_rd_data)
  );

endmodule

// File: doc/bus_sram_slave.md
BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, word-address width; memory is 2^DEPTH_LOG2 words of 32 bits.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
REQ-003 Parameter WAIT_STATES, default 1, extra cycles before ack; range 0..15.
REQ-004 i_clk  in  1  clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_bus_en  in  1  transaction request; held high by master until the cycle after o_ack.
REQ-007 i_wr_en  in  1  1 = write, 0 = read; stable while i_bus_en high.
REQ-008 i_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 i_wr_data  in  32  write data.
REQ-010 i_byte_en  in  4  byte lane enables; bit n selects bits [8n+7:8n].
REQ-011 o_ack  out  1  single-cycle transaction-complete pulse.
REQ-012 o_rd_data  out  32  read data; valid while o_ack high.
REQ-013 o_err  out  1  asserted together with o_ack when the address is out of range.

Function
REQ-014 The FSM SHALL use four states: IDLE, WAIT, ACK, DRAIN.
REQ-015 IDLE: when i_bus_en=1, latch addr/wr_en/wr_data/byte_en; go to WAIT if WAIT_STATES>0, otherwise go to ACK.
REQ-016 WAIT: the counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to ACK.
REQ-017 Latency: o_ack SHALL be high exactly WAIT_STATES+1 cycles after the first cycle i_bus_en is sampled high in IDLE.
REQ-018 ACK: o_ack=1 for exactly one cycle, then go to DRAIN.
REQ-019 DRAIN: o_ack=0; stay until i_bus_en=0, then go to IDLE. No new request is accepted in DRAIN.
REQ-020 In-range test: i_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]; word index = i_addr[DEPTH_LOG2+1:2].
REQ-021 In-range write: on the edge entering ACK, write only the enabled bytes; disabled bytes keep their old value. With i_byte_en=0, ack normally and change nothing.
REQ-022 In-range read: o_rd_data SHALL hold mem[index] during the ACK cycle; i_byte_en is ignored and the full word is returned.
REQ-023 Out-of-range: o_ack=1 and o_err=1 in ACK; no memory write; o_rd_data=0.
REQ-024 o_rd_data SHALL be 0 in every state other than ACK.
REQ-025 If i_bus_en falls in WAIT (protocol violation), the transaction SHALL be aborted: return to IDLE, no ack, no write.
REQ-026 Back-to-back requests: the master drops i_bus_en for at least one cycle after ack. DRAIN→IDLE→accept SHALL add no extra dead cycle beyond that.
REQ-027 Read-after-write to the same word SHALL return the newly written data.

Reset
REQ-028 When i_rst=0 at a clock edge: state=IDLE, counter=0, o_ack=0, o_err=0, o_rd_data=0.
REQ-029 Reset during WAIT or ACK SHALL cancel the transaction. A write not yet committed SHALL NOT occur.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 FSM state encodings and the bus response constants (ACK/ERR codes) SHALL live in the shared arvi defines header, for reuse by other bus slaves.
REQ-032 The byte-enable RAM SHALL be a sub-module bus_sram_array, providing one synchronous write port with 4 lane enables and one read port.
REQ-033 The FSM, counter and address decode SHALL stay in bus_sram_slave.

Verification
REQ-034 WAIT_STATES=1, BASE=0: write 0x0000_0010 ← 0xDEADBEEF with be=4'hF, then read 0x10 → ack 2 cycles after en, o_rd_data=0xDEADBEEF, o_err=0.
REQ-035 After REQ-034, write 0x10 ← 0x11223344 with be=4'b0101, then read → 0xDE22BE44.
REQ-036 Read 0x0001_0000 with DEPTH_LOG2=12 → o_ack=1, o_err=1, o_rd_data=0; memory unchanged.
REQ-037 WAIT_STATES=3: write with en high, drop en in the second WAIT cycle → no ack ever; later read of that word returns its old value.
REQ-038 Pull i_rst=0 in the WAIT of a write of 0xCAFEF00D, release, then read the same word → old value, all outputs 0 during reset.
REQ-039 WAIT_STATES=0: issue a read, hold en one cycle after ack, drop for 1 cycle, issue a second read → acks exactly 1 cycle after each en, each a single-cycle pulse.
